writeback_stage: RTL and testbench

MEM/WB pipeline register and writeback mux of the 5-stage RV32I core. It captures the memory-stage result and extracts/sign-extends load data. It drives the register file's write port (write enable, rd, write data), which the register file samples on the falling clock edge. It also flags misaligned loads and, optionally, counts retired instructions.

---
 rtl/writeback_stage.sv | 171 +++++++++++++++++
 tb/tb_writeback_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register and writeback mux of the RV32I core.
// Captures the memory-stage result, extracts and extends load data, and drives
// the register-file write port. Misaligned loads are flagged and never written.
// Optional feature macro: WB_INSTRET_EN adds WB_instret_o, a wrapping count of
// instructions that leave the stage without faulting.
module writeback_stage #(
  parameter int CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             MEM_valid_i,
  input  logic             MEM_reg_wr_en_i,
  input  logic [4:0]       MEM_rd_i,
  input  logic [1:0]       MEM_wb_sel_i,
  input  logic [31:0]      MEM_alu_result_i,
  input  logic [31:0]      MEM_pc_plus4_i,
  input  logic [31:0]      MEM_load_data_i,
  input  logic [2:0]       MEM_funct3_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             WB_valid_o,
  output logic             WB_reg_wr_en_o,
  output logic [4:0]       WB_rd_o,
  output logic [31:0]      WB_wr_data_o,
  output logic             WB_misalign_o
`ifdef WB_INSTRET_EN
  ,
  output logic [CNT_W-1:0] WB_instret_o
`endif
);

  // Writeback source encodings; 11 is reserved and behaves like the ALU path.
  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  // Load width/sign encodings from funct3.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // The counter needs at least one bit; an empty block documents the bound.
  generate
    if (CNT_W < 1) begin : g_cnt_w_invalid
    end
  endgenerate

  // Stage registers.
  logic        r_valid;
  logic        r_reg_wr_en;
  logic [4:0]  r_rd;
  logic [1:0]  r_wb_sel;
  logic [31:0] r_alu_result;
  logic [31:0] r_pc_plus4;
  logic [31:0] r_load_data;
  logic [2:0]  r_funct3;

  // Combinational results derived only from the stage registers.
  logic [1:0]  w_addr_lo;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;
  logic        w_load_misaligned;
  logic        w_misalign;
  logic        w_wen;
  logic [31:0] w_sel_data;

  // Stage register update: flush beats stall, stall holds, otherwise capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid      <= 1'b0;
      r_reg_wr_en  <= 1'b0;
      r_rd         <= 5'd0;
      r_wb_sel     <= 2'b00;
      r_alu_result <= 32'd0;
      r_pc_plus4   <= 32'd0;
      r_load_data  <= 32'd0;
      r_funct3     <= 3'b000;
    end else if (flush_i) begin
      r_valid      <= 1'b0;
      r_reg_wr_en  <= 1'b0;
      r_rd         <= 5'd0;
      r_wb_sel     <= 2'b00;
      r_alu_result <= 32'd0;
      r_pc_plus4   <= 32'd0;
      r_load_data  <= 32'd0;
      r_funct3     <= 3'b000;
    end else if (!stall_i) begin
      r_valid      <= MEM_valid_i;
      r_reg_wr_en  <= MEM_reg_wr_en_i;
      r_rd         <= MEM_rd_i;
      r_wb_sel     <= MEM_wb_sel_i;
      r_alu_result <= MEM_alu_result_i;
      r_pc_plus4   <= MEM_pc_plus4_i;
      r_load_data  <= MEM_load_data_i;
      r_funct3     <= MEM_funct3_i;
    end
  end

  // Byte/halfword lane selection and extension from the little-endian word.
  always_comb begin
    w_addr_lo = r_alu_result[1:0];
    case (w_addr_lo)
      2'd0:    w_byte = r_load_data[7:0];
      2'd1:    w_byte = r_load_data[15:8];
      2'd2:    w_byte = r_load_data[23:16];
      default: w_byte = r_load_data[31:24];
    endcase
    w_half = w_addr_lo[1] ? r_load_data[31:16] : r_load_data[15:0];
    w_load_misaligned = 1'b0;
    case (r_funct3)
      F3_LB:   w_load_val = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  w_load_val = {24'd0, w_byte};
      F3_LH: begin
        w_load_val        = {{16{w_half[15]}}, w_half};
        w_load_misaligned = w_addr_lo[0];
      end
      F3_LHU: begin
        w_load_val        = {16'd0, w_half};
        w_load_misaligned = w_addr_lo[0];
      end
      F3_LW: begin
        w_load_val        = r_load_data;
        w_load_misaligned = (w_addr_lo != 2'd0);
      end
      // Undefined load encodings pass the raw word and never fault.
      default: w_load_val = r_load_data;
    endcase
  end

  // Writeback source mux and write qualification; rd and data are forced to
  // zero whenever no write happens because the bypass ignores the enable.
  always_comb begin
    case (r_wb_sel)
      SEL_LOAD: w_sel_data = w_load_val;
      SEL_LINK: w_sel_data = r_pc_plus4;
      SEL_ALU:  w_sel_data = r_alu_result;
      default:  w_sel_data = r_alu_result;
    endcase
    w_misalign = r_valid & (r_wb_sel == SEL_LOAD) & w_load_misaligned;
    w_wen      = r_valid & r_reg_wr_en & (r_rd != 5'd0) & ~w_misalign;
  end

  assign WB_valid_o     = r_valid;
  assign WB_misalign_o  = w_misalign;
  assign WB_reg_wr_en_o = w_wen;
  assign WB_rd_o        = w_wen ? r_rd : 5'd0;
  assign WB_wr_data_o   = w_wen ? w_sel_data : 32'd0;

`ifdef WB_INSTRET_EN
  logic [CNT_W-1:0] r_instret;
  logic             w_retire;

  // An instruction retires when it leaves the stage (no stall) without faulting.
  assign w_retire = r_valid & ~stall_i & ~w_misalign;

  // Retire counter, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + 1'b1;
    end
  end

  assign WB_instret_o = r_instret;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed and random checks of writeback_stage against a
// behavioural model of the MEM/WB stage. Counter checks are active when
// WB_INSTRET_EN is defined (the bench uses CNT_W=4 so wrap is reachable).
module tb_writeback_stage;

  localparam int TB_CNT_W = 4;
  localparam longint unsigned CNT_MASK = (64'd1 << TB_CNT_W) - 64'd1;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        MEM_valid_i = 1'b0;
  logic        MEM_reg_wr_en_i = 1'b0;
  logic [4:0]  MEM_rd_i = 5'd0;
  logic [1:0]  MEM_wb_sel_i = 2'd0;
  logic [31:0] MEM_alu_result_i = 32'd0;
  logic [31:0] MEM_pc_plus4_i = 32'd0;
  logic [31:0] MEM_load_data_i = 32'd0;
  logic [2:0]  MEM_funct3_i = 3'd0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        WB_valid_o;
  logic        WB_reg_wr_en_o;
  logic [4:0]  WB_rd_o;
  logic [31:0] WB_wr_data_o;
  logic        WB_misalign_o;
`ifdef WB_INSTRET_EN
  logic [TB_CNT_W-1:0] WB_instret_o;
`endif

  writeback_stage #(.CNT_W(TB_CNT_W)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .MEM_valid_i      (MEM_valid_i),
    .MEM_reg_wr_en_i  (MEM_reg_wr_en_i),
    .MEM_rd_i         (MEM_rd_i),
    .MEM_wb_sel_i     (MEM_wb_sel_i),
    .MEM_alu_result_i (MEM_alu_result_i),
    .MEM_pc_plus4_i   (MEM_pc_plus4_i),
    .MEM_load_data_i  (MEM_load_data_i),
    .MEM_funct3_i     (MEM_funct3_i),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .WB_valid_o       (WB_valid_o),
    .WB_reg_wr_en_o   (WB_reg_wr_en_o),
    .WB_rd_o          (WB_rd_o),
    .WB_wr_data_o     (WB_wr_data_o),
    .WB_misalign_o    (WB_misalign_o)
`ifdef WB_INSTRET_EN
    ,
    .WB_instret_o     (WB_instret_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  // Model of the instruction currently held in the stage.
  bit              m_valid;
  bit              m_wen;
  int unsigned     m_rd;
  int unsigned     m_sel;
  int unsigned     m_alu;
  int unsigned     m_pc4;
  int unsigned     m_ld;
  int unsigned     m_f3;
  longint unsigned m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Value a load returns, from byte/halfword arithmetic on the memory word.
  function automatic int unsigned model_load(int unsigned word, int unsigned addr, int unsigned f3);
    int unsigned a = addr % 4;
    int unsigned b = (word >> (8 * a)) & 32'hFF;
    int unsigned h = (word >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      0: return (b >= 128) ? (b + 32'hFFFFFF00) : b;
      1: return (h >= 32768) ? (h + 32'hFFFF0000) : h;
      4: return b;
      5: return h;
      default: return word;
    endcase
  endfunction

  function automatic bit model_mis();
    int unsigned a = m_alu % 4;
    bit bad;
    if (m_f3 == 1 || m_f3 == 5) bad = (a % 2) != 0;
    else if (m_f3 == 2)         bad = (a != 0);
    else                        bad = 1'b0;
    return m_valid && (m_sel == 1) && bad;
  endfunction

  function automatic bit model_wen();
    return m_valid && m_wen && (m_rd != 0) && !model_mis();
  endfunction

  function automatic int unsigned model_data();
    if (!model_wen()) return 0;
    if (m_sel == 1) return model_load(m_ld, m_alu, m_f3);
    if (m_sel == 2) return m_pc4;
    return m_alu;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_wen = 0; m_rd = 0; m_sel = 0;
    m_alu = 0; m_pc4 = 0; m_ld = 0; m_f3 = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_valid"}, WB_valid_o, m_valid);
    chk({tag, "_wen"},   WB_reg_wr_en_o, model_wen());
    chk({tag, "_rd"},    WB_rd_o, model_wen() ? m_rd : 0);
    chk({tag, "_data"},  WB_wr_data_o, model_data());
    chk({tag, "_mis"},   WB_misalign_o, model_mis());
`ifdef WB_INSTRET_EN
    chk({tag, "_cnt"},   WB_instret_o, m_cnt);
`endif
  endtask

  // One clock of stimulus: drive on the falling edge, advance the model on the
  // rising edge, compare just after it.
  task automatic step(input string tag, input bit v, input bit we, input int unsigned rd,
                      input int unsigned sel, input int unsigned alu, input int unsigned pc4,
                      input int unsigned ld, input int unsigned f3, input bit st, input bit fl);
    @(negedge clk_i);
    MEM_valid_i = v; MEM_reg_wr_en_i = we; MEM_rd_i = rd[4:0]; MEM_wb_sel_i = sel[1:0];
    MEM_alu_result_i = alu; MEM_pc_plus4_i = pc4; MEM_load_data_i = ld;
    MEM_funct3_i = f3[2:0]; stall_i = st; flush_i = fl;
    @(posedge clk_i);
    if (m_valid && !st && !model_mis()) m_cnt = (m_cnt + 1) & CNT_MASK;
    if (fl) model_clear();
    else if (!st) begin
      m_valid = v; m_wen = we; m_rd = rd % 32; m_sel = sel % 4;
      m_alu = alu; m_pc4 = pc4; m_ld = ld; m_f3 = f3 % 8;
    end
    #1;
    check_all(tag);
    $display("[TB] %s v=%0d rd=%0d sel=%0d f3=%0d st=%0d fl=%0d -> wen=%0d rd=%0d data=%08h mis=%0d",
             tag, v, rd % 32, sel % 4, f3 % 8, st, fl, WB_reg_wr_en_o, WB_rd_o, WB_wr_data_o, WB_misalign_o);
  endtask

  // Asynchronous reset in the middle of a cycle, then release before the next edge.
  task automatic mid_cycle_reset(input string tag);
    #2;
    rst_i = 1'b1;
    #1;
    model_clear();
    m_cnt = 0;
    chk({tag, "_rst_valid"}, WB_valid_o, 1'b0);
    chk({tag, "_rst_wen"},   WB_reg_wr_en_o, 1'b0);
    chk({tag, "_rst_rd"},    WB_rd_o, 5'd0);
    chk({tag, "_rst_data"},  WB_wr_data_o, 32'd0);
    chk({tag, "_rst_mis"},   WB_misalign_o, 1'b0);
    rst_i = 1'b0;
    #2;
    check_all({tag, "_released"});
    $display("[TB] %s async reset mid-cycle", tag);
  endtask

  localparam int unsigned WORD = 32'h80FF7F01;

  initial begin
    model_clear();
    m_cnt = 0;
    repeat (2) @(posedge clk_i);
    #1;
    check_all("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

    // ALU writes, including the rd=0 suppression.
    step("alu_rd5", 1, 1, 5, 0, 32'h1234, 0, 0, 0, 0, 0);
    chk("alu_rd5_const", WB_wr_data_o, 32'h00001234);
    step("alu_rd0", 1, 1, 0, 0, 32'h1234, 0, 0, 0, 0, 0);
    chk("alu_rd0_const", WB_reg_wr_en_o, 1'b0);

    // Load extraction from 0x80FF7F01.
    step("lb_a1",  1, 1, 3, 1, 32'h1001, 0, WORD, 0, 0, 0);
    chk("lb_a1_const", WB_wr_data_o, 32'h0000007F);
    step("lb_a2",  1, 1, 3, 1, 32'h1002, 0, WORD, 0, 0, 0);
    chk("lb_a2_const", WB_wr_data_o, 32'hFFFFFFFF);
    step("lbu_a3", 1, 1, 3, 1, 32'h1003, 0, WORD, 4, 0, 0);
    chk("lbu_a3_const", WB_wr_data_o, 32'h00000080);
    step("lh_a2",  1, 1, 3, 1, 32'h1002, 0, WORD, 1, 0, 0);
    chk("lh_a2_const", WB_wr_data_o, 32'hFFFF80FF);
    step("lhu_a0", 1, 1, 3, 1, 32'h1000, 0, WORD, 5, 0, 0);
    chk("lhu_a0_const", WB_wr_data_o, 32'h00007F01);

    // Misaligned loads are flagged and never written.
    step("lw_a2",  1, 1, 7, 1, 32'h2002, 0, WORD, 2, 0, 0);
    chk("lw_a2_mis", WB_misalign_o, 1'b1);
    step("lh_a3",  1, 1, 7, 1, 32'h2003, 0, WORD, 1, 0, 0);
    chk("lh_a3_rd", WB_rd_o, 5'd0);

    // JAL held for three stalled cycles, then released.
    step("jal", 1, 1, 1, 2, 32'hABCD, 32'h104, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("jal_stall", 1, 1, 9, 0, $urandom, $urandom, $urandom, 0, 1, 0);
      chk("jal_stall_data", WB_wr_data_o, 32'h00000104);
    end
    step("jal_release", 1, 1, 4, 0, 32'h55, 0, 0, 0, 0, 0);

    // Reset while a stalled instruction is held discards it.
    step("pre_rst", 1, 1, 6, 0, 32'h77, 0, 0, 0, 0, 0);
    step("pre_rst_stall", 1, 1, 8, 0, 32'h99, 0, 0, 0, 1, 0);
    mid_cycle_reset("stall_rst");
    step("first_capture", 1, 1, 2, 0, 32'hCAFE, 0, 0, 0, 0, 0);

    // Flush wins over stall.
    step("flush_stall", 1, 1, 3, 0, 32'h1, 0, 0, 0, 1, 1);
    chk("flush_stall_valid", WB_valid_o, 1'b0);

    // Sixteen back-to-back retirements wrap a 4-bit counter.
    for (int i = 0; i < 17; i++)
      step("wrap", 1, 1, (i % 31) + 1, 0, i, 0, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 31),
           $urandom_range(0, 3), $urandom, $urandom, $urandom, $urandom_range(0, 7),
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
